cmul_sequencer_2: RTL

- Initiator side of the 4-multiplier complex-multiply interface in the fft_2 datapath.
- Accepts one complex sample plus twiddle index over a valid/ready handshake.
- Looks up the twiddle factor, drives operands and an enable pulse to the complex multiplier, and waits for all four product-ready flags.
- Captures the real/imag result and presents it downstream on a valid/ready output.

---
 rtl/fft_2_pkg.sv | 46 ++++
 rtl/cmul_sequencer_2_if.sv | 42 ++++
 rtl/twiddle_rom_2.sv | 27 ++
 rtl/cmul_sequencer_2.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fft_2_pkg.sv
// rtl/fft_2_pkg.sv - shared fft_2 widths, sequencer state encoding and twiddle table
package fft_2_pkg;

    localparam int DW       = 12;
    localparam int PW       = 24;
    localparam int TW_AW    = 4;
    localparam int TW_SCALE = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } tw_t;

    // W^k = cos(2*pi*k/32) - j*sin(2*pi*k/32), Q4.7, rounded to nearest
    function automatic tw_t tw_lookup(input logic [TW_AW-1:0] k);
        tw_t t;
        case (k)
            4'd0:    t = {12'sd128,  12'sd0};
            4'd1:    t = {12'sd126, -12'sd25};
            4'd2:    t = {12'sd118, -12'sd49};
            4'd3:    t = {12'sd106, -12'sd71};
            4'd4:    t = {12'sd91,  -12'sd91};
            4'd5:    t = {12'sd71,  -12'sd106};
            4'd6:    t = {12'sd49,  -12'sd118};
            4'd7:    t = {12'sd25,  -12'sd126};
            4'd8:    t = {12'sd0,   -12'sd128};
            4'd9:    t = {-12'sd25,  -12'sd126};
            4'd10:   t = {-12'sd49,  -12'sd118};
            4'd11:   t = {-12'sd71,  -12'sd106};
            4'd12:   t = {-12'sd91,  -12'sd91};
            4'd13:   t = {-12'sd106, -12'sd71};
            4'd14:   t = {-12'sd118, -12'sd49};
            4'd15:   t = {-12'sd126, -12'sd25};
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cmul_sequencer_2_if.sv
// rtl/cmul_sequencer_2_if.sv - sample in, multiplier and result-out signal bundle
interface cmul_sequencer_2_if;
    import fft_2_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic [TW_AW-1:0]     tw_idx;

    logic                 mul_en;
    logic signed [DW-1:0] mul_a;
    logic signed [DW-1:0] mul_b;
    logic signed [DW-1:0] mul_c;
    logic signed [DW-1:0] mul_d;
    logic [3:0]           mul_rdy;
    logic signed [PW-1:0] mul_real;
    logic signed [PW-1:0] mul_img;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [PW-1:0] out_re;
    logic signed [PW-1:0] out_im;

    logic                 busy;
    logic                 err_timeout;

    // sequencer side: initiator towards the multiplier
    modport master (
        input  in_valid, in_re, in_im, tw_idx, mul_rdy, mul_real, mul_img, out_ready,
        output in_ready, mul_en, mul_a, mul_b, mul_c, mul_d,
        output out_valid, out_re, out_im, busy, err_timeout
    );

    // environment side: upstream source, multiplier and downstream sink
    modport slave (
        output in_valid, in_re, in_im, tw_idx, mul_rdy, mul_real, mul_img, out_ready,
        input  in_ready, mul_en, mul_a, mul_b, mul_c, mul_d,
        input  out_valid, out_re, out_im, busy, err_timeout
    );

endinterface

// File: rtl/twiddle_rom_2.sv
// rtl/twiddle_rom_2.sv - registered twiddle ROM, 1-cycle latency, output cleared by reset
module twiddle_rom_2
    import fft_2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [TW_AW-1:0]     i_idx,
    output logic signed [DW-1:0] o_re,
    output logic signed [DW-1:0] o_im
);

    tw_t w_tw;
    assign w_tw = tw_lookup(i_idx);

    // load a new factor only when enabled so it holds for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            o_re <= '0;
            o_im <= '0;
        end else if (i_en) begin
            o_re <= w_tw.re;
            o_im <= w_tw.im;
        end
    end

endmodule

// File: rtl/cmul_sequencer_2.sv
// rtl/cmul_sequencer_2.sv - complex-multiply sequencer; CMUL_SEQ_IFFT_CONJ_EN conjugates the twiddle
module cmul_sequencer_2
    import fft_2_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    cmul_sequencer_2_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_t           r_state;
    logic                 r_in_ready;
    logic                 r_mul_en;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_err;
    logic [CW-1:0]        r_cnt;
    logic signed [DW-1:0] r_mul_a;
    logic signed [DW-1:0] r_mul_b;
    logic signed [PW-1:0] r_out_re;
    logic signed [PW-1:0] r_out_im;

    logic                 w_accept;
    logic signed [DW-1:0] w_tw_re;
    logic signed [DW-1:0] w_tw_im;
    logic signed [DW-1:0] w_mul_d;

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

    twiddle_rom_2 u_rom (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_accept),
        .i_idx(bus.tw_idx),
        .o_re (w_tw_re),
        .o_im (w_tw_im)
    );

`ifdef CMUL_SEQ_IFFT_CONJ_EN
    // the most negative value has no positive twin; clamp it to the largest positive
    assign w_mul_d = (w_tw_im == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : -w_tw_im;
`else
    assign w_mul_d = w_tw_im;
`endif

    // transaction FSM; every handshake/status output is registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_mul_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mul_a    <= bus.in_re;
                        r_mul_b    <= bus.in_im;
                        r_mul_en   <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mul_en <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mul_rdy == 4'hF) begin
                        r_out_re    <= bus.mul_real;
                        r_out_im    <= bus.mul_img;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // this WAIT cycle brings the count to TIMEOUT: abandon the sample
                        r_err      <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.mul_en      = r_mul_en;
    assign bus.mul_a       = r_mul_a;
    assign bus.mul_b       = r_mul_b;
    assign bus.mul_c       = w_tw_re;
    assign bus.mul_d       = w_mul_d;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_re      = r_out_re;
    assign bus.out_im      = r_out_im;
    assign bus.busy        = r_busy;
    assign bus.err_timeout = r_err;

endmodule
